// File: rtl/cpu_pkg.sv
// Shared types for the RV32I pipeline control path.
// Decoded-control bundle, forwarding and next-PC encodings.
package cpu_pkg;

    localparam int CPU_REG_W    = 5;
    localparam int CPU_ALU_OP_W = 3;

    typedef struct packed {
        logic                    write;
        logic                    store;
        logic                    load;
        logic                    branch;
        logic [1:0]              alu_a_sel;
        logic                    alu_b_sel;
        logic [1:0]              next_pc_sel;
        logic [CPU_ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_JALR   = 2'b01;
    localparam logic [1:0] NPC_BRANCH = 2'b10;
    localparam logic [1:0] NPC_JAL    = 2'b11;

    // x0 is hardwired to zero, so it never matches a producer.
    function automatic logic reg_hit(
        input logic [CPU_REG_W-1:0] rd,
        input logic [CPU_REG_W-1:0] rs
    );
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding selects for the two EX-stage ALU sources.
// Purely combinational; the younger EX/MEM producer beats MEM/WB.
module forwarding_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_ex_valid,
    input  logic [REG_ADDR_W-1:0] i_ex_rs1,
    input  logic [REG_ADDR_W-1:0] i_ex_rs2,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_write,
    input  logic                  i_mem_load,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    output logic [1:0]            o_fwd_a_sel,
    output logic [1:0]            o_fwd_b_sel
);

    logic w_mem_src;
    logic w_wb_src;

    // A load in MEM has no data yet; only WB may forward load results.
    assign w_mem_src = i_mem_valid & i_mem_write & ~i_mem_load;
    assign w_wb_src  = i_wb_valid & i_wb_write;

    function automatic logic [1:0] pick(
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_ok,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_ok && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_ok && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        o_fwd_a_sel = FWD_NONE;
        o_fwd_b_sel = FWD_NONE;
        if (i_ex_valid) begin
            o_fwd_a_sel = pick(w_mem_src, i_mem_rd, w_wb_src, i_wb_rd, i_ex_rs1);
            o_fwd_b_sel = pick(w_mem_src, i_mem_rd, w_wb_src, i_wb_rd, i_ex_rs2);
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Control path of the 5-stage RV32I pipeline: ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, redirect flush and forwarding.
module control_pipeline
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_write,
    input  logic                  id_store,
    input  logic                  id_load,
    input  logic                  id_branch,
    input  logic [1:0]            id_alu_a_sel,
    input  logic                  id_alu_b_sel,
    input  logic [1:0]            id_next_pc_sel,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_redirect,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  ex_valid,
    output logic                  ex_write,
    output logic                  ex_load,
    output logic                  ex_store,
    output logic                  ex_branch,
    output logic [1:0]            ex_alu_a_sel,
    output logic                  ex_alu_b_sel,
    output logic [1:0]            ex_next_pc_sel,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_valid,
    output logic                  mem_write,
    output logic                  mem_load,
    output logic                  mem_store,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_write,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    ctrl_t                 w_id_ctrl;
    logic                  w_hazard;
    logic                  w_issue;

    logic                  r_ex_valid;
    ctrl_t                 r_ex_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;

    logic                  r_mem_valid;
    logic                  r_mem_write;
    logic                  r_mem_load;
    logic                  r_mem_store;
    logic [REG_ADDR_W-1:0] r_mem_rd;

    logic                  r_wb_valid;
    logic                  r_wb_write;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    always_comb begin
        w_id_ctrl             = '0;
        w_id_ctrl.write       = id_write;
        w_id_ctrl.store       = id_store;
        w_id_ctrl.load        = id_load;
        w_id_ctrl.branch      = id_branch;
        w_id_ctrl.alu_a_sel   = id_alu_a_sel;
        w_id_ctrl.alu_b_sel   = id_alu_b_sel;
        w_id_ctrl.next_pc_sel = id_next_pc_sel;
        w_id_ctrl.alu_op      = id_alu_op;
    end

    assign w_hazard = id_valid & r_ex_valid & r_ex_ctrl.load &
                      ((id_uses_rs1 & reg_hit(r_ex_rd, id_rs1)) |
                       (id_uses_rs2 & reg_hit(r_ex_rd, id_rs2)));

    // Redirect outranks the stall: the stalled instruction is on the wrong path.
    assign stall_if_id = w_hazard & ~ex_redirect;
    assign flush_if_id = ex_redirect;
    assign w_issue     = id_valid & ~w_hazard & ~ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
        end else begin
            r_ex_valid <= w_issue;
            r_ex_ctrl  <= w_issue ? w_id_ctrl : '0;
            r_ex_rd    <= w_issue ? id_rd  : '0;
            r_ex_rs1   <= w_issue ? id_rs1 : '0;
            r_ex_rs2   <= w_issue ? id_rs2 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_load  <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_rd    <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_write <= r_ex_valid & r_ex_ctrl.write;
            r_mem_load  <= r_ex_valid & r_ex_ctrl.load;
            r_mem_store <= r_ex_valid & r_ex_ctrl.store;
            r_mem_rd    <= r_ex_valid ? r_ex_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_write <= 1'b0;
            r_wb_rd    <= '0;
        end else begin
            r_wb_valid <= r_mem_valid;
            r_wb_write <= r_mem_valid & r_mem_write;
            r_wb_rd    <= r_mem_valid ? r_mem_rd : '0;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_write       = r_ex_valid & r_ex_ctrl.write;
    assign ex_load        = r_ex_valid & r_ex_ctrl.load;
    assign ex_store       = r_ex_valid & r_ex_ctrl.store;
    assign ex_branch      = r_ex_valid & r_ex_ctrl.branch;
    assign ex_alu_a_sel   = r_ex_valid ? r_ex_ctrl.alu_a_sel : '0;
    assign ex_alu_b_sel   = r_ex_valid & r_ex_ctrl.alu_b_sel;
    assign ex_next_pc_sel = r_ex_valid ? r_ex_ctrl.next_pc_sel : '0;
    assign ex_alu_op      = r_ex_valid ? r_ex_ctrl.alu_op : '0;
    assign ex_rd          = r_ex_valid ? r_ex_rd : '0;

    assign mem_valid = r_mem_valid;
    assign mem_write = r_mem_valid & r_mem_write;
    assign mem_load  = r_mem_valid & r_mem_load;
    assign mem_store = r_mem_valid & r_mem_store;
    assign mem_rd    = r_mem_valid ? r_mem_rd : '0;

    assign wb_valid = r_wb_valid;
    assign wb_write = r_wb_valid & r_wb_write;
    assign wb_rd    = r_wb_valid ? r_wb_rd : '0;

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .i_ex_valid  (r_ex_valid),
        .i_ex_rs1    (r_ex_rs1),
        .i_ex_rs2    (r_ex_rs2),
        .i_mem_valid (mem_valid),
        .i_mem_write (mem_write),
        .i_mem_load  (mem_load),
        .i_mem_rd    (mem_rd),
        .i_wb_valid  (wb_valid),
        .i_wb_write  (wb_write),
        .i_wb_rd     (wb_rd),
        .o_fwd_a_sel (fwd_a_sel),
        .o_fwd_b_sel (fwd_b_sel)
    );

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Consumer end of the decoded-control interface in the RV32I 5-stage pipelined CPU.
- Takes per-instruction control bits from the decode stage and carries them through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and stalls the pipeline on them.
- Applies branch/jump flushes.
- Generates the operand forwarding selects for the EX stage.

Parameters:
- REG_ADDR_W, 5, register index width.
- ALU_OP_W, 3, width of the ALU operation select.

Ports:
- clk in 1: system clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- id_valid in 1: the decode stage holds a real instruction.
- id_write, id_store, id_load, id_branch in 1 each: decoded control bits.
- id_alu_a_sel in 2: ALU operand A select.
- id_alu_b_sel in 1: ALU operand B select.
- id_next_pc_sel in 2: next-PC select.
- id_alu_op in ALU_OP_W: ALU operation.
- id_rd, id_rs1, id_rs2 in REG_ADDR_W each: register indices.
- id_uses_rs1, id_uses_rs2 in 1 each: the instruction reads rs1/rs2.
- ex_redirect in 1: a taken branch or jump is resolved in EX this cycle.
- stall_if_id out 1: hold the PC and the IF/ID register.
- flush_if_id out 1: load a bubble into IF/ID.
- ex_valid, ex_write, ex_load, ex_store, ex_branch out 1 each.
- ex_alu_a_sel out 2, ex_alu_b_sel out 1, ex_next_pc_sel out 2, ex_alu_op out ALU_OP_W.
- ex_rd out REG_ADDR_W.
- fwd_a_sel, fwd_b_sel out 2 each: forwarding selects for ALU sources rs1/rs2.
- mem_valid, mem_write, mem_load, mem_store out 1 each; mem_rd out REG_ADDR_W.
- wb_valid, wb_write out 1 each; wb_rd out REG_ADDR_W.

Behaviour:

Reset and stage registers:
- One clock; reset is asynchronous and active-low.
- On reset, every registered output is 0: all valid bits, all control bits, all selects and all rd fields.
- Three stage registers: ID/EX, EX/MEM, MEM/WB. Each advances every cycle with 1-cycle latency per stage.
- ID/EX also stores rs1 and rs2 internally; these are not output.

Bubble qualification:
- A bubble means valid=0 and every control field is 0.
- Outputs are always qualified: when a stage's valid is 0, its write/load/store/branch outputs are 0.

Load-use hazard:
- hazard = id_valid & ex_valid & ex_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- On hazard with no redirect: stall_if_id=1, flush_if_id=0, ID/EX loads a bubble, EX/MEM and MEM/WB advance normally.
- A stall lasts exactly one cycle. Next cycle the load is in MEM and the dependent instruction issues.

Redirect:
- On ex_redirect=1: flush_if_id=1, stall_if_id=0 even if hazard is 1 (redirect has priority), and ID/EX loads a bubble.
- The redirecting instruction itself advances into EX/MEM unchanged.

Normal issue:
- With neither hazard nor redirect: stall_if_id=0, flush_if_id=0.
- ID/EX loads the id_* fields, with valid = id_valid.

Forwarding (combinational from registered state; fwd_b_sel uses the same rule on stored rs2):
- fwd_a_sel = 2'b01 (EX/MEM result) if mem_valid & mem_write & !mem_load & mem_rd != 0 & mem_rd == stored rs1.
- Otherwise 2'b10 (MEM/WB result) if wb_valid & wb_write & wb_rd != 0 & wb_rd == stored rs1.
- Otherwise 2'b00 (register file).
- When both EX/MEM and MEM/WB match, EX/MEM wins because it is the younger producer.
- Register x0 never forwards and never causes a hazard.
- Forwarding selects are 00 when ex_valid=0.

Reset mid-operation: all stages return immediately to bubbles. No partial instruction survives.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ctrl_t packed struct: write, store, load, branch, alu_a_sel, alu_b_sel, next_pc_sel, alu_op.
  - FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Next-PC encodings: 00 sequential, 01 jalr, 10 branch, 11 jal.
- One sub-module: forwarding_unit. It is purely combinational and is instantiated once, with outputs for both sources.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 asynchronously, before the next clk edge.
- Back-to-back ALU dependency: addi x5 (write, rd=5) followed by r-type rs1=5 -> fwd_a_sel=01 in the consumer's EX cycle. With one unrelated instruction between them -> fwd_a_sel=10.
- Load-use: lw rd=7 in EX, ID instruction uses rs2=7 -> stall_if_id=1 for exactly 1 cycle and ex_valid=0 the next cycle. When the consumer then reaches EX, fwd_b_sel=10.
- x0 guard: lw rd=0 followed by a consumer with rs1=0 -> no stall; fwd_a_sel=00.
- Redirect vs hazard: ex_redirect=1 while the hazard condition holds -> flush_if_id=1, stall_if_id=0, ID/EX is a bubble, and the redirecting instruction appears in mem_* with its write bit intact.
- Double match: rd=3 in both MEM and WB, EX consumer rs1=3 -> fwd_a_sel=01.
